// File: rtl/rob_ch.sv
// rob_fifo: single-bank response FIFO; pointers carry a wrap flag to tell full from empty.
// Latency: a word pushed on edge t is at the head from cycle t+1; head is read combinationally.
// Backpressure: full comes from registered pointers only, so a same-cycle pop never admits a push.
module rob_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  // {wrap flag, pointer}: a plain binary increment of the AW+1 bit value wraps the
  // pointer to 0 and toggles the flag when it steps past DEPTH-1.
  logic [AW:0]  wr_cnt;
  logic [AW:0]  rd_cnt;
  logic [W-1:0] mem [DEPTH];

  assign empty    = (wr_cnt[AW-1:0] == rd_cnt[AW-1:0]) && (wr_cnt[AW] == rd_cnt[AW]);
  assign full     = (wr_cnt[AW-1:0] == rd_cnt[AW-1:0]) && (wr_cnt[AW] != rd_cnt[AW]);
  assign head_dat = mem[rd_cnt[AW-1:0]];

  // Pointer advance; push and pop in the same cycle move both and keep occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + (AW+1)'(1);
      if (pop)  rd_cnt <= rd_cnt + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_cnt[AW-1:0]] <= push_dat;
  end
endmodule

// rob_ch: per-channel reorder stage returning bank responses in key-order-buffer order.
// Latency: 2 cycles from bank push into an empty FIFO to u_rsp_valid when the kob entry waits.
// Backpressure: a stalled output register blocks kob_ack and pops; full bank FIFOs drop bank_rsp_ready.
module rob_ch #(
  parameter int BANKS      = 4,
  parameter int BANK_ID_W  = 2,
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    kob_req,
  input  logic [BANK_ID_W-1:0]    kob_bank_id,
  output logic                    kob_ack,
  input  logic [BANKS-1:0]        bank_rsp_valid,
  input  logic [BANKS*DATA_W-1:0] bank_rsp_data,
  output logic [BANKS-1:0]        bank_rsp_ready,
  output logic                    u_rsp_valid,
  input  logic                    u_rsp_ready,
  output logic [DATA_W-1:0]       u_rsp_data,
  output logic [BANK_ID_W-1:0]    u_rsp_bank_id
);
  logic [BANKS-1:0]  empty;
  logic [BANKS-1:0]  full;
  logic [BANKS-1:0]  push;
  logic [BANKS-1:0]  pop;
  logic [DATA_W-1:0] head_dat [BANKS];
  logic              out_free;

  assign bank_rsp_ready = ~full;
  assign push           = bank_rsp_valid & ~full;
  assign out_free       = ~u_rsp_valid | u_rsp_ready;

  // Only the bank named by the oldest kob entry may retire; other banks wait,
  // which is what keeps the channel in request order.
  assign kob_ack = kob_req & ~empty[kob_bank_id] & out_free;

  // One-hot pop of the selected bank on acknowledge.
  always_comb begin
    pop = '0;
    if (kob_ack) pop[kob_bank_id] = 1'b1;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    rob_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[b]),
      .push_dat (bank_rsp_data[b*DATA_W +: DATA_W]),
      .pop      (pop[b]),
      .head_dat (head_dat[b]),
      .empty    (empty[b]),
      .full     (full[b])
    );
  end

  // Output register: reload on ack (back-to-back when the old word is taken), clear valid on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_rsp_valid   <= 1'b0;
      u_rsp_data    <= '0;
      u_rsp_bank_id <= '0;
    end else if (kob_ack) begin
      u_rsp_valid   <= 1'b1;
      u_rsp_data    <= head_dat[kob_bank_id];
      u_rsp_bank_id <= kob_bank_id;
    end else if (u_rsp_ready) begin
      u_rsp_valid   <= 1'b0;
    end
  end

  // Upstream protocol checks: kob must name a real bank; a refused bank response must be held.
  a_bank_id_range: assert property (@(posedge clk) disable iff (!rst_n)
    kob_req |-> (int'(kob_bank_id) < BANKS));

  for (genvar b = 0; b < BANKS; b++) begin : g_rsp_hold
    a_rsp_not_dropped: assert property (@(posedge clk) disable iff (!rst_n)
      (bank_rsp_valid[b] && !bank_rsp_ready[b]) |=> bank_rsp_valid[b]);
  end
endmodule

// File: tb/tb_rob_ch.sv
// Bench for rob_ch: bench plays the key order buffer, banks and channel.
// Expected data: the n-th kob entry naming bank b receives the n-th word pushed into bank b.
// Observations are taken 1 time unit after inputs settle, inputs change 1 unit after the clock edge.
module tb_rob_ch;
  localparam int BANKS      = 4;
  localparam int BANK_ID_W  = 2;
  localparam int DATA_W     = 128;
  localparam int FIFO_DEPTH = 4;

  logic                    clk            = 1'b0;
  logic                    rst_n          = 1'b0;
  logic                    kob_req        = 1'b0;
  logic [BANK_ID_W-1:0]    kob_bank_id    = '0;
  logic                    kob_ack;
  logic [BANKS-1:0]        bank_rsp_valid = '0;
  logic [BANKS*DATA_W-1:0] bank_rsp_data  = '0;
  logic [BANKS-1:0]        bank_rsp_ready;
  logic                    u_rsp_valid;
  logic                    u_rsp_ready    = 1'b0;
  logic [DATA_W-1:0]       u_rsp_data;
  logic [BANK_ID_W-1:0]    u_rsp_bank_id;

  rob_ch #(
    .BANKS      (BANKS),
    .BANK_ID_W  (BANK_ID_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kob_req        (kob_req),
    .kob_bank_id    (kob_bank_id),
    .kob_ack        (kob_ack),
    .bank_rsp_valid (bank_rsp_valid),
    .bank_rsp_data  (bank_rsp_data),
    .bank_rsp_ready (bank_rsp_ready),
    .u_rsp_valid    (u_rsp_valid),
    .u_rsp_ready    (u_rsp_ready),
    .u_rsp_data     (u_rsp_data),
    .u_rsp_bank_id  (u_rsp_bank_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-bank push history and the kob entry list.
  logic [DATA_W-1:0] push_mem [int];
  int  push_cnt [BANKS];
  int  kob_cnt  [BANKS];
  int  kob_bank_hist [$];
  int  kob_idx_hist  [$];
  int  kq [$];
  int  out_cnt;
  bit  kob_en;

  // Per-cycle observations.
  logic                 obs_ack, obs_vld, obs_fire;
  logic [DATA_W-1:0]    obs_dat;
  logic [BANK_ID_W-1:0] obs_bank;
  logic [BANKS-1:0]     obs_rdy, obs_push;
  int                   obs_idx;

  function automatic int key(input int b, input int n);
    return b * 65536 + n;
  endfunction

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    push_mem.delete();
    kob_bank_hist.delete();
    kob_idx_hist.delete();
    kq.delete();
    out_cnt = 0;
    for (int b = 0; b < BANKS; b++) begin
      push_cnt[b] = 0;
      kob_cnt[b]  = 0;
    end
  endtask

  task automatic kob_add(input int b);
    kq.push_back(b);
    kob_bank_hist.push_back(b);
    kob_idx_hist.push_back(kob_cnt[b]);
    kob_cnt[b]++;
  endtask

  // Expected word and bank for the i-th response delivered since reset.
  function automatic bit exp_out(input int i, output logic [DATA_W-1:0] d,
                                 output logic [BANK_ID_W-1:0] bk);
    d  = '0;
    bk = '0;
    if (i >= kob_bank_hist.size()) return 1'b0;
    bk = BANK_ID_W'(kob_bank_hist[i]);
    if (!push_mem.exists(key(kob_bank_hist[i], kob_idx_hist[i]))) return 1'b0;
    d = push_mem[key(kob_bank_hist[i], kob_idx_hist[i])];
    return 1'b1;
  endfunction

  task automatic set_push(input int b, input logic [DATA_W-1:0] v);
    bank_rsp_valid[b] = 1'b1;
    bank_rsp_data[b*DATA_W +: DATA_W] = v;
  endtask

  // One clock cycle: present kob head, observe, record handshakes, advance past the edge.
  task automatic step();
    kob_req     = kob_en && (kq.size() != 0);
    kob_bank_id = (kq.size() != 0) ? BANK_ID_W'(kq[0]) : '0;
    #1;
    obs_ack  = kob_ack;
    obs_vld  = u_rsp_valid;
    obs_fire = u_rsp_valid & u_rsp_ready;
    obs_dat  = u_rsp_data;
    obs_bank = u_rsp_bank_id;
    obs_rdy  = bank_rsp_ready;
    obs_push = bank_rsp_valid & bank_rsp_ready;
    obs_idx  = out_cnt;
    for (int b = 0; b < BANKS; b++) begin
      if (obs_push[b]) begin
        push_mem[key(b, push_cnt[b])] = bank_rsp_data[b*DATA_W +: DATA_W];
        push_cnt[b]++;
      end
    end
    if (obs_fire) out_cnt++;
    if (kob_ack && kq.size() != 0) void'(kq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; kob_en = 1'b0; kob_req = 1'b1; kob_bank_id = 2'd2;
    bank_rsp_valid = '0; u_rsp_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (u_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", u_rsp_valid); end
    n_cmp++; if (u_rsp_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", u_rsp_data); end
    n_cmp++; if (u_rsp_bank_id !== '0) begin n_bad++; $display("FAIL reset_bank: got %0d want 0", u_rsp_bank_id); end
    n_cmp++; if (bank_rsp_ready !== 4'hF) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", bank_rsp_ready); end
    n_cmp++; if (kob_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", kob_ack); end
    kob_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    kob_en = 1'b1; u_rsp_ready = 1'b1;
    kob_add(2);
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++; if (obs_ack !== 1'b0) begin n_bad++; $display("FAIL lat_stall: ack %b want 0 at cycle %0d", obs_ack, c); end
    end
    set_push(2, 128'hA5);
    step();
    bank_rsp_valid = '0;
    n_cmp++; if (obs_ack !== 1'b0 || obs_push[2] !== 1'b1) begin n_bad++; $display("FAIL lat_push: ack %b push %b want 0 1", obs_ack, obs_push[2]); end
    step();
    n_cmp++; if (obs_ack !== 1'b1 || obs_vld !== 1'b0) begin n_bad++; $display("FAIL lat_ack: ack %b valid %b want 1 0", obs_ack, obs_vld); end
    step();
    n_cmp++; if (obs_vld !== 1'b1 || obs_dat !== 128'hA5 || obs_bank !== 2'd2) begin
      n_bad++; $display("FAIL lat_out: valid %b data %h bank %0d want 1 a5 2", obs_vld, obs_dat, obs_bank); end
    step();
    n_cmp++; if (obs_vld !== 1'b0) begin n_bad++; $display("FAIL lat_drop: valid %b want 0", obs_vld); end
  endtask

  task automatic test_out_of_order();
    logic [DATA_W-1:0]    want_d [3];
    logic [BANK_ID_W-1:0] want_b [3];
    int k;
    want_d[0] = rnd128(); want_d[1] = rnd128(); want_d[2] = rnd128();
    want_b[0] = 2'd0; want_b[1] = 2'd1; want_b[2] = 2'd3;
    kob_en = 1'b1; u_rsp_ready = 1'b1;
    kob_add(0); kob_add(1); kob_add(3);
    set_push(3, want_d[2]); step(); bank_rsp_valid = '0;
    n_cmp++; if (obs_ack !== 1'b0) begin n_bad++; $display("FAIL ooo_early_ack0: ack %b want 0", obs_ack); end
    set_push(1, want_d[1]); step(); bank_rsp_valid = '0;
    n_cmp++; if (obs_ack !== 1'b0) begin n_bad++; $display("FAIL ooo_early_ack1: ack %b want 0", obs_ack); end
    step();
    n_cmp++; if (obs_ack !== 1'b0) begin n_bad++; $display("FAIL ooo_early_ack2: ack %b want 0", obs_ack); end
    set_push(0, want_d[0]); step(); bank_rsp_valid = '0;
    n_cmp++; if (obs_ack !== 1'b0) begin n_bad++; $display("FAIL ooo_early_ack3: ack %b want 0", obs_ack); end
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (obs_ack !== (c < 3)) begin n_bad++; $display("FAIL ooo_ack: cycle %0d ack %b want %b", c, obs_ack, (c < 3)); end
      n_cmp++; if (obs_fire !== (c >= 1 && c <= 3)) begin n_bad++; $display("FAIL ooo_fire: cycle %0d valid %b want %b", c, obs_fire, (c >= 1 && c <= 3)); end
      if (obs_fire && k < 3) begin
        n_cmp++;
        if (obs_dat !== want_d[k] || obs_bank !== want_b[k]) begin
          n_bad++; $display("FAIL ooo_data: item %0d got bank %0d data %h want bank %0d data %h", k, obs_bank, obs_dat, want_b[k], want_d[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] ed;
    logic [BANK_ID_W-1:0] eb;
    logic [DATA_W-1:0] first_d;
    int acks, fires;
    kob_en = 1'b0; u_rsp_ready = 1'b0;
    first_d = rnd128();
    set_push(2, first_d); set_push(0, rnd128()); set_push(1, rnd128());
    step();
    bank_rsp_valid = '0;
    kob_add(2); kob_add(0); kob_add(1);
    kob_en = 1'b1;
    step();
    acks = obs_ack ? 1 : 0;
    n_cmp++; if (obs_ack !== 1'b1) begin n_bad++; $display("FAIL bp_first_ack: ack %b want 1", obs_ack); end
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (obs_vld !== 1'b1 || obs_dat !== first_d || obs_ack !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold: cycle %0d valid %b ack %b data %h want 1 0 %h", c, obs_vld, obs_ack, obs_dat, first_d);
      end
    end
    u_rsp_ready = 1'b1;
    fires = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (obs_ack) acks++;
      n_cmp++; if (obs_fire !== (c < 3)) begin n_bad++; $display("FAIL bp_rate: cycle %0d fire %b want %b", c, obs_fire, (c < 3)); end
      if (obs_fire) begin
        fires++;
        n_cmp++;
        if (!exp_out(obs_idx, ed, eb) || obs_dat !== ed || obs_bank !== eb) begin
          n_bad++; $display("FAIL bp_data: got bank %0d data %h want bank %0d data %h", obs_bank, obs_dat, eb, ed);
        end
      end
    end
    n_cmp++; if (acks != 3 || fires != 3) begin n_bad++; $display("FAIL bp_count: acks %0d fires %0d want 3 3", acks, fires); end
  endtask

  task automatic test_full_wrap();
    logic [DATA_W-1:0] base;
    int k;
    base = 128'h1000;
    kob_en = 1'b0; u_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_push(1, base + DATA_W'(i));
      step();
      n_cmp++; if (obs_push[1] !== 1'b1) begin n_bad++; $display("FAIL full_fill: push %0d accepted %b want 1", i, obs_push[1]); end
    end
    bank_rsp_valid = '0;
    step();
    n_cmp++; if (obs_rdy[1] !== 1'b0) begin n_bad++; $display("FAIL full_ready: ready %b want 0", obs_rdy[1]); end
    set_push(1, base + DATA_W'(4));
    kob_add(1); kob_en = 1'b1;
    step();
    n_cmp++; if (obs_rdy[1] !== 1'b0 || obs_ack !== 1'b1 || obs_push[1] !== 1'b0) begin
      n_bad++; $display("FAIL full_pop_cycle: ready %b ack %b push %b want 0 1 0", obs_rdy[1], obs_ack, obs_push[1]); end
    step();
    n_cmp++; if (obs_rdy[1] !== 1'b1 || obs_push[1] !== 1'b1) begin
      n_bad++; $display("FAIL full_reopen: ready %b push %b want 1 1", obs_rdy[1], obs_push[1]); end
    set_push(1, base + DATA_W'(5));
    for (int i = 0; i < 5; i++) kob_add(1);
    u_rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      step();
      if (obs_push[1]) bank_rsp_valid[1] = 1'b0;
      if (obs_fire) begin
        n_cmp++;
        if (obs_dat !== base + DATA_W'(k) || obs_bank !== 2'd1) begin
          n_bad++; $display("FAIL wrap_order: item %0d got bank %0d data %h want bank 1 data %h", k, obs_bank, obs_dat, base + DATA_W'(k));
        end
        k++;
      end
    end
    n_cmp++; if (k != 6) begin n_bad++; $display("FAIL wrap_count: got %0d responses want 6", k); end
    bank_rsp_valid = '0;
  endtask

  task automatic test_simul_push_pop();
    logic [DATA_W-1:0] ed;
    logic [BANK_ID_W-1:0] eb;
    int fires;
    kob_en = 1'b0; u_rsp_ready = 1'b1;
    set_push(0, rnd128()); step(); bank_rsp_valid = '0;
    kob_en = 1'b1;
    fires = 0;
    for (int c = 0; c < 10; c++) begin
      set_push(0, rnd128());
      kob_add(0);
      step();
      n_cmp++;
      if (obs_ack !== 1'b1 || obs_push[0] !== 1'b1 || obs_rdy[0] !== 1'b1) begin
        n_bad++; $display("FAIL simul_cycle: cycle %0d ack %b push %b ready %b want 1 1 1", c, obs_ack, obs_push[0], obs_rdy[0]);
      end
      if (obs_fire) begin
        fires++;
        n_cmp++;
        if (!exp_out(obs_idx, ed, eb) || obs_dat !== ed || obs_bank !== eb) begin
          n_bad++; $display("FAIL simul_data: got bank %0d data %h want bank %0d data %h", obs_bank, obs_dat, eb, ed);
        end
      end
    end
    bank_rsp_valid = '0;
    kob_add(0);
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_fire) begin
        fires++;
        n_cmp++;
        if (!exp_out(obs_idx, ed, eb) || obs_dat !== ed || obs_bank !== eb) begin
          n_bad++; $display("FAIL simul_drain: got bank %0d data %h want bank %0d data %h", obs_bank, obs_dat, eb, ed);
        end
      end
    end
    n_cmp++; if (fires != 11) begin n_bad++; $display("FAIL simul_count: got %0d responses want 11", fires); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] ed;
    logic [BANK_ID_W-1:0] eb;
    int fires;
    kob_en = 1'b0; u_rsp_ready = 1'b0;
    set_push(3, rnd128()); set_push(2, rnd128()); step(); bank_rsp_valid = '0;
    set_push(3, rnd128()); step(); bank_rsp_valid = '0;
    kob_add(3); kob_en = 1'b1;
    step();
    step();
    n_cmp++; if (obs_vld !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: valid %b want 1", obs_vld); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (u_rsp_valid !== 1'b0 || u_rsp_data !== '0) begin n_bad++; $display("FAIL rmid_out: valid %b data %h want 0 0", u_rsp_valid, u_rsp_data); end
    n_cmp++; if (bank_rsp_ready !== 4'hF) begin n_bad++; $display("FAIL rmid_ready: got %b want 1111", bank_rsp_ready); end
    model_clear();
    kob_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    kob_add(3); kob_add(2); kob_en = 1'b1; u_rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (obs_vld !== 1'b0 || obs_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_stale: cycle %0d valid %b ack %b want 0 0", c, obs_vld, obs_ack); end
    end
    set_push(3, rnd128()); set_push(2, rnd128()); step(); bank_rsp_valid = '0;
    fires = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (obs_fire) begin
        fires++;
        n_cmp++;
        if (!exp_out(obs_idx, ed, eb) || obs_dat !== ed || obs_bank !== eb) begin
          n_bad++; $display("FAIL rmid_data: got bank %0d data %h want bank %0d data %h", obs_bank, obs_dat, eb, ed);
        end
      end
    end
    n_cmp++; if (fires != 2) begin n_bad++; $display("FAIL rmid_count: got %0d responses want 2", fires); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ed;
    logic [BANK_ID_W-1:0] eb;
    int b, total, done;
    kob_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < BANKS; i++)
        if (!bank_rsp_valid[i] && $urandom_range(2) == 0) set_push(i, rnd128());
      for (int i = 0; i < 2; i++) begin
        b = $urandom_range(BANKS-1);
        if (kob_cnt[b] < push_cnt[b]) kob_add(b);
      end
      u_rsp_ready = ($urandom_range(3) != 0);
      step();
      bank_rsp_valid = bank_rsp_valid & ~obs_push;
      if (obs_fire) begin
        n_cmp++;
        if (!exp_out(obs_idx, ed, eb) || obs_dat !== ed || obs_bank !== eb) begin
          n_bad++; $display("FAIL rand_data: item %0d got bank %0d data %h want bank %0d data %h", obs_idx, obs_bank, obs_dat, eb, ed);
        end
      end
    end
    u_rsp_ready = 1'b1;
    done = 0;
    for (int c = 0; c < 300 && done == 0; c++) begin
      for (int i = 0; i < BANKS; i++)
        while (kob_cnt[i] < push_cnt[i]) kob_add(i);
      step();
      bank_rsp_valid = bank_rsp_valid & ~obs_push;
      if (obs_fire) begin
        n_cmp++;
        if (!exp_out(obs_idx, ed, eb) || obs_dat !== ed || obs_bank !== eb) begin
          n_bad++; $display("FAIL rand_drain: item %0d got bank %0d data %h want bank %0d data %h", obs_idx, obs_bank, obs_dat, eb, ed);
        end
      end
      total = 0;
      for (int i = 0; i < BANKS; i++) total += push_cnt[i];
      if (bank_rsp_valid == '0 && out_cnt == total && kob_bank_hist.size() == total) done = 1;
    end
    total = 0;
    for (int i = 0; i < BANKS; i++) total += push_cnt[i];
    n_cmp++; if (out_cnt != total) begin n_bad++; $display("FAIL rand_count: delivered %0d want %0d", out_cnt, total); end
    bank_rsp_valid = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_out_of_order();
    test_backpressure();
    test_full_wrap();
    test_simul_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rob_ch.md
Name: rob_ch

Overview:
- Per-channel response reorder stage that sits directly downstream of the key order buffer.
- Load responses return from the banks out of channel order; each bank's responses are buffered in their own FIFO.
- The key order buffer presents the bank_id of the oldest outstanding load. This block pops that bank's head entry and returns data to the upstream channel in original request order.
- One instance per channel.

Parameters:
BANKS, 4, number of cache banks; power of 2
BANK_ID_W, 2, log2(BANKS)
DATA_W, 128, response word width (clWordWidth)
FIFO_DEPTH, 4, entries per bank FIFO; power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset
kob_req  in  1  key order buffer has a valid oldest entry
kob_bank_id  in  BANK_ID_W  bank holding the oldest outstanding load
kob_ack  out  1  entry consumed; key order buffer advances its retire pointer
bank_rsp_valid  in  BANKS  per-bank response valid
bank_rsp_data  in  BANKS*DATA_W  per-bank response data, bank b at [b*DATA_W +: DATA_W]
bank_rsp_ready  out  BANKS  per-bank FIFO can accept
u_rsp_valid  out  1  in-order response to channel
u_rsp_ready  in  1  channel accepts response
u_rsp_data  out  DATA_W  response data
u_rsp_bank_id  out  BANK_ID_W  source bank of response

Behaviour:
Clocking and reset:
- Single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all FIFO read/write pointers and wrap flags = 0; bank FIFOs empty; output register empty.
- Output values in reset: u_rsp_valid=0, u_rsp_data=0, u_rsp_bank_id=0, bank_rsp_ready=all 1, kob_ack=0.
- Reset asserted mid-operation discards all buffered data immediately. No response is emitted after reset until new bank pushes arrive.

Bank FIFOs (one per bank b):
- Pointers are log2(FIFO_DEPTH) bits plus a wrap flag.
- Empty: pointers equal and flags equal. Full: pointers equal and flags differ.
- The pointer wraps to 0 and the flag toggles on increment from FIFO_DEPTH-1.
- bank_rsp_ready[b] = ~full[b], taken from registered state only. It does not rise combinationally when a pop occurs in the same cycle.
- Push: bank_rsp_valid[b] & bank_rsp_ready[b]. Data is written at the write pointer on the clock edge.
- Simultaneous push and pop on the same bank is legal: occupancy is unchanged and both pointers advance.
- Storage is not reset; only pointers are reset.

Ordering and acknowledge:
- out_free = ~u_rsp_valid | u_rsp_ready.
- kob_ack = kob_req & ~empty[kob_bank_id] & out_free. This is combinational; it is the only path from kob_req/kob_bank_id to outputs.
- On kob_ack:
  - pop the head of FIFO[kob_bank_id];
  - load the output register with that data and kob_bank_id;
  - set u_rsp_valid=1 on the next edge.
- If kob_req=1 but the selected FIFO is empty, kob_ack=0 and the request stalls. Other banks' data is never bypassed, which guarantees in-order return.
- kob_req=0 forces kob_ack=0.

Output register:
- u_rsp_valid, u_rsp_data and u_rsp_bank_id come from registers.
- While u_rsp_valid & ~u_rsp_ready, the outputs hold stable and no pop occurs.
- When the output is accepted and a new ack happens in the same cycle, the register is reloaded and valid stays 1: back-to-back, one response per cycle.
- When the output is accepted with no ack, u_rsp_valid falls to 0 on the next edge.

Latency:
- Bank push at edge t into an empty FIFO with kob_req waiting: kob_ack is high in cycle t+1, and u_rsp_valid is high from edge t+1 to t+2 (visible in cycle t+2).
- Minimum bank-to-channel latency is 2 cycles.

Error cases:
- A pop from an empty FIFO or a push to a full FIFO cannot occur by construction.
- Simulation assertions flag kob_bank_id >= BANKS and any bank_rsp_valid with ready=0 that is dropped (illegal upstream behaviour).

Test Plan:
1. Reset, then kob_req=1, kob_bank_id=2, and push 0xA5 on bank 2 at cycle 3. Required: kob_ack=1 in cycle 4, u_rsp_valid=1 in cycle 5 with data=0xA5 and bank_id=2.
2. Out-of-order arrival:
   - Pushes arrive in the order bank3 D3 and bank1 D1 before bank0 D0.
   - kob sequence is 0,1,3 with u_rsp_ready=1.
   - Required: outputs D0, D1, D3 in that order on consecutive cycles once D0 arrives, with no ack before D0 arrives.
3. Backpressure: hold u_rsp_ready=0 for 5 cycles with 3 entries queued. Required: u_rsp_data stable and kob_ack=0 throughout. After release, one response per cycle and 3 acks total.
4. FIFO full and wrap on bank 1, no kob_req:
   - Push 4 words; required: bank_rsp_ready[1]=0 after the 4th push.
   - Pop 1 with a simultaneous push attempt; required: ready stays 0 that cycle and returns to 1 the next cycle.
   - Pop all remaining entries; required: 6 pushes over the sequence return in FIFO order across the pointer wrap.
5. Simultaneous push and pop on bank 0 every cycle for 10 cycles with FIFO occupancy 1. Required: occupancy stays 1, ready stays 1, data emerges in order.
6. Reset asserted while 2 entries are buffered and u_rsp_valid=1. Required: u_rsp_valid=0 immediately, all bank_rsp_ready=1, and no stale data output after reset release.
